noise_acq_seq: RTL

Sequencer for the noise acquisition path. It latches the divider and sample-count configuration on `noise_load` and paces ADC sampling from `clk_sys`. It generates write enables and addresses for the 4096x12 noise RAM, then serves host readout by converting the asynchronous `XRD` strobe into single-cycle RAM read enables with an auto-incrementing read pointer. It replaces the free-running clock, enable and address fragments with one synchronous controller in the `clk_sys` domain.

---
 rtl/noise_acq_seq_if.sv | 30 +++
 rtl/noise_acq_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/noise_acq_seq_if.sv
// RAM-side bus of the noise acquisition sequencer.
// It carries the write port (enable, address, data) and the read port (enable, address).
interface noise_acq_seq_if #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 12
);
  logic          ram_wen;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wd;
  logic          ram_ren;
  logic [AW-1:0] ram_raddr;

  // The sequencer drives the RAM ports.
  modport master (
    output ram_wen,
    output ram_waddr,
    output ram_wd,
    output ram_ren,
    output ram_raddr
  );

  // The RAM or an observer receives them.
  modport slave (
    input ram_wen,
    input ram_waddr,
    input ram_wd,
    input ram_ren,
    input ram_raddr
  );
endinterface

// File: rtl/noise_acq_seq.sv
// Noise acquisition sequencer.
// The controller paces ADC sampling with a programmable divider and writes each sample into
// the noise RAM. It then serves host readout by turning the asynchronous active-low XRD strobe
// into single-cycle RAM read enables with an auto-incrementing read pointer.
// All logic runs in the clk_sys domain.
module noise_acq_seq #(
  parameter int unsigned AW   = 12,
  parameter int unsigned DW   = 12,
  parameter int unsigned DIVW = 10
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  input  logic            noise_load,
  input  logic [DIVW-1:0] n_divnum,
  input  logic [AW-1:0]   n_acqnum,
  input  logic            abort,
  input  logic [DW-1:0]   n_ADC,
  input  logic            XRD,
  input  logic            RAM_RDaddr_rst,
  noise_acq_seq_if.master ram,
  output logic            sample_strobe,
  output logic            acq_busy,
  output logic            acq_done,
  output logic [AW-1:0]   wr_count,
  output logic            rd_err
);

  typedef enum logic [1:0] {StIdle, StAcq, StDone} state_t;

  state_t          state;
  logic [DIVW-1:0] div_r;
  logic [AW-1:0]   num_r;
  logic [DIVW-1:0] divcnt;
  // A zero-length run still reports completion one cycle after entering DONE.
  logic            zero_pend;

  logic            xrd_s1;
  logic            xrd_s2;
  logic            xrd_h;
  logic            rd_edge;
  logic            load_fire;
  logic            tick;

  // A sample tick fires when the divider matches. Ticks stop once the last sample is written
  // or when abort drops the tick in the same cycle.
  assign tick = rst_n && (state == StAcq) && !abort && (wr_count != num_r) &&
                (divcnt == div_r);

  assign sample_strobe = tick;
  assign acq_busy      = (state == StAcq);
  assign load_fire     = noise_load && (state != StAcq);
  assign rd_edge       = xrd_h && !xrd_s2;

  // Acquisition controller: state, divider, write port and completion pulse.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state         <= StIdle;
      div_r         <= '0;
      num_r         <= '0;
      divcnt        <= '0;
      zero_pend     <= 1'b0;
      wr_count      <= '0;
      acq_done      <= 1'b0;
      ram.ram_wen   <= 1'b0;
      ram.ram_waddr <= '0;
      ram.ram_wd    <= '0;
    end else begin
      ram.ram_wen <= 1'b0;
      acq_done    <= 1'b0;
      unique case (state)
        StIdle, StDone: begin
          if (noise_load) begin
            div_r         <= n_divnum;
            num_r         <= n_acqnum;
            divcnt        <= '0;
            wr_count      <= '0;
            ram.ram_waddr <= '0;
            zero_pend     <= (n_acqnum == '0);
            state         <= (n_acqnum == '0) ? StDone : StAcq;
          end else if (zero_pend) begin
            zero_pend <= 1'b0;
            acq_done  <= 1'b0 | 1'b1;
          end
        end
        StAcq: begin
          if (abort) begin
            // An already-issued write still completes because ram_wen is registered.
            state <= StIdle;
          end else if (wr_count == num_r) begin
            // The final write was issued last cycle.
            state    <= StDone;
            acq_done <= 1'b1;
          end else if (tick) begin
            divcnt        <= '0;
            ram.ram_wen   <= 1'b1;
            ram.ram_wd    <= n_ADC;
            ram.ram_waddr <= wr_count;
            wr_count      <= wr_count + 1'b1;
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Read side: XRD synchronizer, falling-edge detection, read enable, pointer and error flag.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      xrd_s1        <= 1'b0;
      xrd_s2        <= 1'b0;
      xrd_h         <= 1'b0;
      ram.ram_ren   <= 1'b0;
      ram.ram_raddr <= '0;
      rd_err        <= 1'b0;
    end else begin
      xrd_s1      <= XRD;
      xrd_s2      <= xrd_s1;
      xrd_h       <= xrd_s2;
      ram.ram_ren <= 1'b0;
      if (load_fire || RAM_RDaddr_rst) begin
        // A pointer reset wins over a coincident read edge.
        ram.ram_raddr <= '0;
        rd_err        <= 1'b0;
      end else begin
        // The pointer advances in the cycle after the read enable so the RAM sees it stable.
        if (ram.ram_ren) begin
          ram.ram_raddr <= ram.ram_raddr + 1'b1;
        end
        if (rd_edge) begin
          if ((state == StAcq) || (ram.ram_raddr >= wr_count)) begin
            rd_err <= 1'b1;
          end else begin
            ram.ram_ren <= 1'b1;
          end
        end
      end
    end
  end

endmodule
